bus_ctrl_reg: RTL and testbench
===============================

Name: bus_ctrl_reg

Overview:
- Registered, parametrised single-master bus controller between the CPU LSU and N memory-mapped slaves (ram, timer, uart, gpio, spi, ...).
- Decodes a configurable address field against per-slave base/mask pairs.
- Supports one outstanding transaction and returns an error response for unmapped addresses and for slave timeouts.
- Replaces the flat combinational bus decode in the SoC top.

Parameters:
- N_SLV, 5, number of slave ports (1..16).
- DEC_LO, 12, LSB of decoded address field; field is m_addr_i[31:DEC_LO].
- DEC_W, 20, width of decoded field; must equal 32-DEC_LO.
- SLV_BASE, {20'h00006,20'h00005,20'h00004,20'h00002,20'h00000}, N_SLV*DEC_W flattened bases; slave k occupies bits [k*DEC_W +: DEC_W].
- SLV_MASK, {20'hFFFFF,20'hFFFFF,20'hFFFFF,20'hFFFFE,20'hFFFFE}, flattened masks; slave k hits when (field & mask_k) == (base_k & mask_k).
- TIMEOUT_CYC, 255, maximum WAIT cycles before an error response (1..65535).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: synchronous, active-high.
- m_req_i  in  1  master request; sampled only while m_ready_o=1.
- m_sel_i  in  4  byte enables.
- m_addr_i  in  32  byte address.
- m_we_i  in  1  1=write, 0=read.
- m_data_i  in  32  write data.
- m_ready_o  out  1  controller idle, accepts a request.
- m_rvalid_o  out  1  one-cycle response strobe (read data or write ack).
- m_data_o  out  32  read data, valid with m_rvalid_o.
- m_err_o  out  1  error flag, valid with m_rvalid_o.
- s_req_o  out  N_SLV  one-hot request, one-cycle pulse.
- s_sel_o  out  4  shared, latched byte enables.
- s_addr_o  out  32  shared, latched address.
- s_we_o  out  1  shared, latched write enable.
- s_data_o  out  32  shared, latched write data.
- s_rvalid_i  in  N_SLV  per-slave response strobe (reads and writes).
- s_data_i  in  N_SLV*32  flattened read data; slave k at [k*32 +: 32].

Behaviour:
- Reset values:
  - All outputs 0 except m_ready_o=1.
  - State IDLE.
  - Latched address, data, sel, we and index registers 0.
  - Timeout counter 0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - m_ready_o=1.
  - On m_req_i=1: latch sel/addr/we/data into s_*_o and decode.
  - Decode is priority-encoded; the lowest slave index wins on overlap.
  - On a hit: store index, pulse s_req_o[idx] for exactly the next cycle, go to WAIT, m_ready_o=0.
  - On a miss: go to RESP with err pending; no s_req_o pulse.
- WAIT:
  - The timeout counter increments each cycle.
  - s_rvalid_i[idx]=1: capture s_data_i slice idx, go to RESP with err=0.
  - Response strobes from non-selected slaves are ignored.
  - Counter reaches TIMEOUT_CYC without a response: go to RESP with err=1, data 0.
  - A response and timeout in the same cycle: the response wins, err=0.
- RESP:
  - m_rvalid_o=1 for exactly one cycle with m_data_o/m_err_o.
  - On a write ack, m_data_o is the slave data unchanged.
  - On error, m_data_o=32'h0.
  - Next cycle: IDLE, m_ready_o=1, m_rvalid_o=0, counter cleared.
- m_data_o and m_err_o hold their value until the next RESP.
- Latency:
  - Request accepted at edge T gives s_req_o high in cycle T+1.
  - A slave response sampled at edge U gives m_rvalid_o high in cycle U+1.
  - A miss accepted at T gives m_rvalid_o high in cycle T+1.
- A zero-wait slave (s_rvalid_i in the same cycle as s_req_o) is legal: 2-cycle round trip.
- m_req_i while m_ready_o=0 is ignored, not queued; the master holds it until accepted.
- Reset asserted mid-transaction: everything returns to reset values on the next edge. A late slave s_rvalid_i after reset is ignored (state IDLE).
- s_sel_o/s_addr_o/s_we_o/s_data_o stay stable from acceptance through RESP.

Optional Feature:
- BUS_TIMEOUT_EN
  - Defined: the timeout counter and timeout error are present as described above.
  - Undefined: no counter; WAIT exits only on s_rvalid_i[idx]. m_err_o is asserted only for unmapped addresses.

Test Plan:
- Read 0x00001004, slave0 drives rvalid 2 cycles after its s_req_o with data 0xA5A5_0001 -> s_req_o=5'b00001 one cycle; m_rvalid_o one cycle later with data 0xA5A50001, m_err_o=0.
- Write 0x00005000 data 0x41, sel 4'b0001, uart acks immediately -> s_req_o=5'b01000, s_data_o=0x41, s_sel_o=4'b0001; m_rvalid_o 2 cycles after acceptance, m_err_o=0.
- Read 0x00008000 (unmapped) -> no s_req_o bit ever set; m_rvalid_o=1, m_err_o=1, m_data_o=0 in the cycle after acceptance.
- Read 0x00004000, timer never responds, BUS_TIMEOUT_EN defined -> m_rvalid_o with m_err_o=1, data 0 after 255 WAIT cycles; m_ready_o=1 on the following cycle.
- During WAIT on slave 2, pulse s_rvalid_i[3] with data 0xFFFF_FFFF, then s_rvalid_i[2] with 0x1234 -> the first pulse is ignored; m_data_o=0x1234.
- Assert rst_i for one cycle in WAIT, then slave rvalid -> all outputs reset, m_ready_o=1, no m_rvalid_o pulse.

Source files
------------

// File: rtl/bus_ctrl_reg_if.sv
// LSU-side handshake of bus_ctrl_reg.
// master: the CPU load/store unit; slave: the bus controller.
interface bus_ctrl_reg_if;
  logic        m_req_i;
  logic [3:0]  m_sel_i;
  logic [31:0] m_addr_i;
  logic        m_we_i;
  logic [31:0] m_data_i;
  logic        m_ready_o;
  logic        m_rvalid_o;
  logic [31:0] m_data_o;
  logic        m_err_o;

  modport master (
    output m_req_i, m_sel_i, m_addr_i, m_we_i, m_data_i,
    input  m_ready_o, m_rvalid_o, m_data_o, m_err_o
  );

  modport slave (
    input  m_req_i, m_sel_i, m_addr_i, m_we_i, m_data_i,
    output m_ready_o, m_rvalid_o, m_data_o, m_err_o
  );
endinterface

// File: rtl/bus_ctrl_reg.sv
// Registered single-master bus controller: one outstanding transaction,
// base/mask address decode with lowest-index priority, error response
// for unmapped addresses.
// Optional macro BUS_TIMEOUT_EN: adds a WAIT-state timeout counter that
// returns an error response after TIMEOUT_CYC cycles without a slave ack.
module bus_ctrl_reg #(
  parameter int unsigned N_SLV       = 5,
  parameter int unsigned DEC_LO      = 12,
  parameter int unsigned DEC_W       = 20,
  parameter logic [N_SLV*DEC_W-1:0] SLV_BASE =
    {20'h00006, 20'h00005, 20'h00004, 20'h00002, 20'h00000},
  parameter logic [N_SLV*DEC_W-1:0] SLV_MASK =
    {20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFE, 20'hFFFFE},
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  bus_ctrl_reg_if.slave       m_if,
  output logic [N_SLV-1:0]    s_req_o,
  output logic [3:0]          s_sel_o,
  output logic [31:0]         s_addr_o,
  output logic                s_we_o,
  output logic [31:0]         s_data_o,
  input  logic [N_SLV-1:0]    s_rvalid_i,
  input  logic [N_SLV*32-1:0] s_data_i
);
  localparam int unsigned IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        addr_q, addr_d;
  logic               we_q, we_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [N_SLV-1:0]   sreq_q, sreq_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
`ifdef BUS_TIMEOUT_EN
  logic [15:0]        cnt_q, cnt_d;
`endif

  logic [DEC_W-1:0]   field;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;

  assign field = m_if.m_addr_i[31:DEC_LO];

  // Priority decode: scan high to low so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if ((field & SLV_MASK[k*DEC_W +: DEC_W]) ==
          (SLV_BASE[k*DEC_W +: DEC_W] & SLV_MASK[k*DEC_W +: DEC_W])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  // Next-state and datapath update for the IDLE/WAIT/RESP sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    sreq_d  = '0;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (m_if.m_req_i) begin
          sel_d   = m_if.m_sel_i;
          addr_d  = m_if.m_addr_i;
          we_d    = m_if.m_we_i;
          wdata_d = m_if.m_data_i;
          if (hit) begin
            idx_d   = hit_idx;
            sreq_d  = N_SLV'(1) << hit_idx;
            state_d = WAIT;
          end else begin
            // Unmapped: answer straight away with an error.
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
`ifdef BUS_TIMEOUT_EN
        cnt_d = cnt_q + 16'd1;
`endif
        // Only the selected slave's strobe counts; it beats a timeout.
        if (s_rvalid_i[idx_q]) begin
          rdata_d = s_data_i[idx_q*32 +: 32];
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q + 16'd1 == 16'(TIMEOUT_CYC)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
`ifdef BUS_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      sreq_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      sreq_q  <= sreq_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign m_if.m_ready_o  = (state_q == IDLE);
  assign m_if.m_rvalid_o = (state_q == RESP);
  assign m_if.m_data_o   = rdata_q;
  assign m_if.m_err_o    = err_q;
  assign s_req_o         = sreq_q;
  assign s_sel_o         = sel_q;
  assign s_addr_o        = addr_q;
  assign s_we_o          = we_q;
  assign s_data_o        = wdata_q;
endmodule

// File: tb/tb_bus_ctrl_reg.sv
// Directed bench for bus_ctrl_reg with a response scoreboard.
module tb_bus_ctrl_reg;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_ctrl_reg_if bif();
  logic [N-1:0]    s_req;
  logic [3:0]      s_sel;
  logic [31:0]     s_addr;
  logic            s_we;
  logic [31:0]     s_wdata;
  logic [N-1:0]    s_rvalid;
  logic [N*32-1:0] s_rdata;

  bus_ctrl_reg dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .m_if       (bif),
    .s_req_o    (s_req),
    .s_sel_o    (s_sel),
    .s_addr_o   (s_addr),
    .s_we_o     (s_we),
    .s_data_o   (s_wdata),
    .s_rvalid_i (s_rvalid),
    .s_data_i   (s_rdata)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Present a request for one cycle; returns in the cycle after acceptance.
  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] d,
                       input logic [3:0] sel, input logic push,
                       input logic [31:0] exp_d, input logic exp_e);
    chk("ready_before_req", 32'(bif.m_ready_o), 32'd1);
    bif.m_req_i  = 1'b1;
    bif.m_addr_i = a;
    bif.m_we_i   = we;
    bif.m_data_i = d;
    bif.m_sel_i  = sel;
    if (push) sb.push_back('{data: exp_d, err: exp_e});
    step();
    bif.m_req_i  = 1'b0;
    bif.m_addr_i = '0;
    bif.m_data_i = '0;
    bif.m_we_i   = 1'b0;
    bif.m_sel_i  = '0;
  endtask

  // Slave k strobes its response in the current cycle.
  task automatic slave_rsp(input int k, input logic [31:0] d);
    s_rvalid[k]          = 1'b1;
    s_rdata[k*32 +: 32]  = d;
    step();
    s_rvalid = '0;
  endtask

  task automatic check_rsp(input string tag);
    rsp_t r;
    chk({tag, "_rvalid"}, 32'(bif.m_rvalid_o), 32'd1);
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL %s_sb: observed response with empty scoreboard, expected none", tag);
    end else begin
      r = sb.pop_front();
      chk({tag, "_data"}, bif.m_data_o, r.data);
      chk({tag, "_err"}, 32'(bif.m_err_o), 32'(r.err));
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 32'(bif.m_ready_o), 32'd1);
    chk({tag, "_rvalid0"}, 32'(bif.m_rvalid_o), 32'd0);
  endtask

  initial begin
    int seen;
    int n;
    rst          = 1'b1;
    bif.m_req_i  = 1'b0;
    bif.m_sel_i  = '0;
    bif.m_addr_i = '0;
    bif.m_we_i   = 1'b0;
    bif.m_data_i = '0;
    s_rvalid     = '0;
    s_rdata      = '0;
    step(2);
    rst = 1'b0;

    // Reset state
    check_idle("rst");
    chk("rst_sreq", 32'(s_req), 32'd0);
    chk("rst_addr", s_addr, 32'd0);
    chk("rst_mdata", bif.m_data_o, 32'd0);
    chk("rst_merr", 32'(bif.m_err_o), 32'd0);

    // Read slave0, response two cycles after s_req_o
    issue(32'h0000_1004, 1'b0, 32'h0, 4'hF, 1'b1, 32'hA5A5_0001, 1'b0);
    chk("rd0_sreq", 32'(s_req), 32'b00001);
    chk("rd0_saddr", s_addr, 32'h0000_1004);
    chk("rd0_busy", 32'(bif.m_ready_o), 32'd0);
    step();
    chk("rd0_sreq_pulse", 32'(s_req), 32'd0);
    step();
    chk("rd0_wait_rvalid0", 32'(bif.m_rvalid_o), 32'd0);
    slave_rsp(0, 32'hA5A5_0001);
    check_rsp("rd0");
    step();
    check_idle("rd0_after");
    chk("rd0_hold", bif.m_data_o, 32'hA5A5_0001);

    // Write to uart, zero-wait ack; ack data passes through unchanged
    issue(32'h0000_5000, 1'b1, 32'h41, 4'b0001, 1'b1, 32'hDEAD_0041, 1'b0);
    chk("wr3_sreq", 32'(s_req), 32'b01000);
    chk("wr3_sdata", s_wdata, 32'h41);
    chk("wr3_ssel", 32'(s_sel), 32'b0001);
    chk("wr3_swe", 32'(s_we), 32'd1);
    slave_rsp(3, 32'hDEAD_0041);
    check_rsp("wr3");
    chk("wr3_saddr_stable", s_addr, 32'h0000_5000);
    step();
    check_idle("wr3_after");

    // Unmapped address
    issue(32'h0000_8000, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1);
    chk("miss_sreq", 32'(s_req), 32'd0);
    check_rsp("miss");
    step();
    check_idle("miss_after");
    chk("miss_sreq2", 32'(s_req), 32'd0);

    // Boundary of slave1's masked window, zero-wait
    issue(32'h0000_3FFC, 1'b0, 32'h0, 4'hF, 1'b1, 32'h3333_3333, 1'b0);
    chk("rd1_sreq", 32'(s_req), 32'b00010);
    slave_rsp(1, 32'h3333_3333);
    check_rsp("rd1");
    step();

    // Timer never responds
`ifdef BUS_TIMEOUT_EN
    issue(32'h0000_4000, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1);
    n = 0;
    while (!bif.m_rvalid_o && n < 400) begin
      step();
      n++;
    end
    chk("to_wait_cycles", 32'(n), 32'd255);
    check_rsp("to");
    step();
    check_idle("to_after");
`else
    issue(32'h0000_4000, 1'b0, 32'h0, 4'hF, 1'b1, 32'h7777_0002, 1'b0);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (bif.m_rvalid_o) seen++;
      step();
    end
    chk("noto_rvalid_cnt", 32'(seen), 32'd0);
    chk("noto_busy", 32'(bif.m_ready_o), 32'd0);
    slave_rsp(2, 32'h7777_0002);
    check_rsp("noto");
    step();
    check_idle("noto_after");
`endif

    // Foreign strobe ignored; request during WAIT ignored
    issue(32'h0000_4010, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0000_1234, 1'b0);
    bif.m_req_i  = 1'b1;
    bif.m_addr_i = 32'h0000_6000;
    slave_rsp(3, 32'hFFFF_FFFF);
    bif.m_req_i  = 1'b0;
    bif.m_addr_i = '0;
    chk("ign_rvalid0", 32'(bif.m_rvalid_o), 32'd0);
    chk("ign_busy", 32'(bif.m_ready_o), 32'd0);
    chk("ign_saddr", s_addr, 32'h0000_4010);
    chk("ign_sreq", 32'(s_req), 32'd0);
    slave_rsp(2, 32'h0000_1234);
    check_rsp("ign");
    step();

    // Reset mid-WAIT, then a late slave strobe
    issue(32'h0000_2000, 1'b1, 32'hCAFE_F00D, 4'b1100, 1'b0, 32'h0, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle("mrst");
    chk("mrst_sreq", 32'(s_req), 32'd0);
    chk("mrst_saddr", s_addr, 32'd0);
    chk("mrst_sdata", s_wdata, 32'd0);
    chk("mrst_ssel", 32'(s_sel), 32'd0);
    chk("mrst_swe", 32'(s_we), 32'd0);
    chk("mrst_mdata", bif.m_data_o, 32'd0);
    chk("mrst_merr", 32'(bif.m_err_o), 32'd0);
    slave_rsp(1, 32'hBAD0_BAD0);
    check_idle("mrst_late");
    chk("mrst_mdata_late", bif.m_data_o, 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
